// File: rtl/de0_pwm_sequencer_pkg.sv
// Shared constants and types for the de0_pwm_sequencer PWM controller.
package de0_pwm_pkg;

  localparam int CNT_W = 16;

  localparam logic [3:0] ADDR_CTRL      = 4'd0;
  localparam logic [3:0] ADDR_PERIOD    = 4'd1;
  localparam logic [3:0] ADDR_STEP      = 4'd2;
  localparam logic [3:0] ADDR_STATUS    = 4'd3;
  localparam logic [3:0] ADDR_DUTY_BASE = 4'd8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/de0_pwm_sequencer_if.sv
// Avalon-MM slave bus bundle for the PWM sequencer register file.
interface de0_pwm_sequencer_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/de0_pwm_sequencer_counter.sv
// Period FSM, free-running counter, boundary-latched shadows and duty compare.
module de0_pwm_counter #(
  parameter int CNT_W = de0_pwm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_idle,
  output logic             o_load,
  output logic             o_terminal,
  output logic             o_pwm
);
  import de0_pwm_pkg::*;

  pwm_state_e       r_state;
  pwm_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per_sh;
  logic [CNT_W-1:0] r_duty_sh;
  logic             w_terminal;

  assign w_terminal = (r_state == RUN) && (r_cnt == r_per_sh);

  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = LOAD;
        LOAD:    w_state_nxt = RUN;
        RUN:     if (w_terminal) w_state_nxt = LOAD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Shadows change only in LOAD, so register writes never glitch a running period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_per_sh  <= '0;
      r_duty_sh <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_cnt     <= '0;
          r_per_sh  <= i_period;
          r_duty_sh <= i_duty;
        end
        RUN:     r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_idle     = (r_state == IDLE);
  assign o_load     = (r_state == LOAD);
  assign o_terminal = w_terminal;
  assign o_pwm      = (r_state == RUN) && (r_cnt < r_duty_sh);

endmodule

// File: rtl/de0_pwm_sequencer.sv
// Avalon-MM PWM controller: register file, read mux, auto-step sequencer and irq.
module de0_pwm_sequencer #(
  parameter int CNT_W    = de0_pwm_pkg::CNT_W,
  parameter int NUM_DUTY = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  de0_pwm_sequencer_if.slave   avs,
  input  logic [2:0]           duty_num,
  output logic                 pwm_out,
  output logic                 irq
);
  import de0_pwm_pkg::*;

  localparam int IDX_W = $clog2(NUM_DUTY);

  logic [2:0]       r_ctrl;
  logic [CNT_W-1:0] r_period;
  logic [7:0]       r_step;
  logic             r_done;
  logic [CNT_W-1:0] r_duty [NUM_DUTY];
  logic [7:0]       r_step_sh;
  logic [7:0]       r_step_cnt;
  logic [IDX_W-1:0] r_seq_idx;
  logic [IDX_W-1:0] r_act_idx;

  logic             w_wr;
  logic             w_en_eff;
  logic [IDX_W-1:0] w_idx;
  logic             w_idle;
  logic             w_load;
  logic             w_terminal;
  logic             w_unused;

  assign w_wr     = avs.chipselect && !avs.write_n;
  assign w_unused = ^avs.writedata[31:CNT_W];

  // A write to EN acts on the very next edge, hence the bypass around r_ctrl.
  assign w_en_eff = (w_wr && avs.address == ADDR_CTRL) ? avs.writedata[CTRL_EN] : r_ctrl[CTRL_EN];
  assign w_idx    = r_ctrl[CTRL_AUTO] ? r_seq_idx : duty_num[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl   <= '0;
      r_period <= '0;
      r_step   <= '0;
      for (int i = 0; i < NUM_DUTY; i++) r_duty[i] <= '0;
    end else if (w_wr) begin
      if (avs.address >= ADDR_DUTY_BASE) begin
        r_duty[avs.address[IDX_W-1:0]] <= avs.writedata[CNT_W-1:0];
      end else begin
        case (avs.address)
          ADDR_CTRL:   r_ctrl   <= avs.writedata[2:0];
          ADDR_PERIOD: r_period <= avs.writedata[CNT_W-1:0];
          ADDR_STEP:   r_step   <= avs.writedata[7:0];
          default:     ;
        endcase
      end
    end
  end

  // A terminal in the same cycle as a clear-write keeps DONE set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                                     r_done <= 1'b0;
    else if (w_terminal)                                              r_done <= 1'b1;
    else if (w_wr && avs.address == ADDR_STATUS && avs.writedata[0]) r_done <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step_sh  <= '0;
      r_act_idx  <= '0;
      r_step_cnt <= '0;
      r_seq_idx  <= '0;
    end else begin
      if (w_load) begin
        r_step_sh <= r_step;
        r_act_idx <= w_idx;
      end
      if (!r_ctrl[CTRL_AUTO] || w_idle) begin
        r_step_cnt <= '0;
        r_seq_idx  <= '0;
      end else if (w_terminal) begin
        if (r_step_cnt == r_step_sh) begin
          r_step_cnt <= '0;
          r_seq_idx  <= r_seq_idx + 1'b1;
        end else begin
          r_step_cnt <= r_step_cnt + 1'b1;
        end
      end
    end
  end

  de0_pwm_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_en       (w_en_eff),
    .i_period   (r_period),
    .i_duty     (r_duty[w_idx]),
    .o_idle     (w_idle),
    .o_load     (w_load),
    .o_terminal (w_terminal),
    .o_pwm      (pwm_out)
  );

  assign irq = r_done & r_ctrl[CTRL_IRQ_EN];

  always_comb begin
    avs.readdata = '0;
    if (avs.address >= ADDR_DUTY_BASE) begin
      avs.readdata[CNT_W-1:0] = r_duty[avs.address[IDX_W-1:0]];
    end else begin
      case (avs.address)
        ADDR_CTRL:   avs.readdata[2:0]       = r_ctrl;
        ADDR_PERIOD: avs.readdata[CNT_W-1:0] = r_period;
        ADDR_STEP:   avs.readdata[7:0]       = r_step;
        ADDR_STATUS: begin
          avs.readdata[0]          = r_done;
          avs.readdata[4 +: IDX_W] = r_act_idx;
        end
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_de0_pwm_sequencer.sv
// Self-checking bench for de0_pwm_sequencer: register table, directed period sequences, randomized model.
module tb_de0_pwm_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] duty_num = 3'd0;
  logic       pwm_out;
  logic       irq;

  de0_pwm_sequencer_if bus();

  de0_pwm_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus),
    .duty_num (duty_num),
    .pwm_out  (pwm_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit       rec_on = 1'b0;
  bit       rec_q[$];
  bit [2:0] idx_q[$];

  always @(negedge clk) begin
    if (rec_on) begin
      rec_q.push_back(pwm_out);
      idx_q.push_back(bus.readdata[6:4]);
    end
  end

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
    bus.address = addr;
    #1;
    data = bus.readdata;
  endtask

  // Returns one cycle into LOAD (j=0); recording starts with that cycle's sample.
  task automatic start_run(input logic [31:0] ctrl);
    bus_write(4'd0, 32'd0);
    rec_q.delete();
    idx_q.delete();
    bus_write(4'd0, ctrl);
    rec_on = 1'b1;
  endtask

  task automatic record_until(input int n);
    for (int i = 0; i < 400 && rec_q.size() < n; i++) @(negedge clk);
    @(posedge clk);
    rec_on = 1'b0;
    check("rec_len_ok", (rec_q.size() >= n), 1);
  endtask

  function automatic int count_high(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) if (i < rec_q.size()) s += rec_q[i];
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int p, s, len, idx, pos, n;
    bit auto_m, exp_pwm;
    int dtab[8];

    vecs[0] = '{4'd1,  32'hABCD_1234, 32'h0000_1234};
    vecs[1] = '{4'd2,  32'hFFFF_FF5A, 32'h0000_005A};
    vecs[2] = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{4'd7,  32'h1234_5678, 32'h0000_0000};
    vecs[4] = '{4'd8,  32'h0001_0005, 32'h0000_0005};
    vecs[5] = '{4'd15, 32'hFFFF_8001, 32'h0000_8001};
    vecs[6] = '{4'd0,  32'hFFFF_FFF6, 32'h0000_0006};
    vecs[7] = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{4'd0,  32'h0000_0000, 32'h0000_0000};

    bus.address    = 4'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", pwm_out, 0);
    check("reset_irq", irq, 0);
    foreach (vecs[i]) begin
      read_reg(vecs[i].addr, rd);
      check("reset_readdata", rd, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Register map table
    foreach (vecs[i]) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      read_reg(vecs[i].addr, rd);
      check($sformatf("regmap_addr%0d", vecs[i].addr), rd, vecs[i].exp);
    end

    // Basic period: PERIOD=9, DUTY[3]=4
    bus_write(4'd1, 32'd9);
    bus_write(4'd11, 32'd4);
    duty_num = 3'd3;
    start_run(32'd1);
    record_until(23);
    check("basic_load_low", rec_q[0], 0);
    check("basic_rise_t2", rec_q[1], 1);
    check("basic_high_p0", count_high(1, 10), 4);
    check("basic_load2_low", rec_q[11], 0);
    check("basic_high_p1", count_high(12, 21), 4);
    check("basic_rise_p1", rec_q[12], 1);
    read_reg(4'd3, rd);
    check("basic_done", rd[0], 1);

    // Mid-period duty write affects only the next period
    start_run(32'd1);
    repeat (3) @(posedge clk);
    bus_write(4'd11, 32'd7);
    record_until(23);
    check("midwr_high_cur", count_high(1, 10), 4);
    check("midwr_high_next", count_high(12, 21), 7);

    // Duty 0 and duty beyond the period
    bus_write(4'd8, 32'd0);
    bus_write(4'd9, 32'd20);
    duty_num = 3'd0;
    start_run(32'd1);
    record_until(23);
    check("duty0_never_high", count_high(0, 22), 0);
    duty_num = 3'd1;
    start_run(32'd1);
    record_until(12);
    check("dutybig_load_low", rec_q[0], 0);
    check("dutybig_high_all", count_high(1, 10), 10);
    check("dutybig_load2_low", rec_q[11], 0);

    // Auto-step: PERIOD=3, STEP=1 -> index advances every 2 periods, wraps after 7
    bus_write(4'd1, 32'd3);
    bus_write(4'd2, 32'd1);
    start_run(32'd3);
    bus.address = 4'd3;
    record_until(90);
    for (int k = 0; k < 18; k++) check($sformatf("auto_idx_p%0d", k), idx_q[k*5+2], (k/2) % 8);

    // DONE set wins over a same-cycle clear; later clear drops irq
    bus_write(4'd1, 32'd9);
    start_run(32'd5);
    repeat (20) @(posedge clk);
    bus_write(4'd3, 32'd1);
    @(negedge clk);
    check("irq_set_wins", irq, 1);
    check("done_set_wins", bus.readdata[0], 1);
    bus_write(4'd3, 32'd1);
    @(negedge clk);
    check("irq_cleared", irq, 0);
    check("done_cleared", bus.readdata[0], 0);
    rec_on = 1'b0;

    // Reset mid-RUN
    bus_write(4'd11, 32'd4);
    duty_num = 3'd3;
    start_run(32'd5);
    repeat (12) @(posedge clk);
    #2;
    check("prereset_pwm", pwm_out, 1);
    check("prereset_irq", irq, 1);
    rec_on = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_pwm", pwm_out, 0);
    check("midreset_irq", irq, 0);
    read_reg(4'd0, rd);  check("midreset_ctrl", rd, 0);
    read_reg(4'd1, rd);  check("midreset_period", rd, 0);
    read_reg(4'd3, rd);  check("midreset_status", rd, 0);
    read_reg(4'd11, rd); check("midreset_duty3", rd, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rec_q.delete();
    idx_q.delete();
    rec_on = 1'b1;
    record_until(15);
    check("postreset_no_pwm", count_high(0, 14), 0);
    check("postreset_no_irq", irq, 0);

    // Randomized trials against a period-level model
    for (int t = 0; t < 10; t++) begin
      auto_m = (t >= 5);
      p = $urandom_range(0, 5);
      s = $urandom_range(0, 1);
      bus_write(4'd0, 32'd0);
      bus_write(4'd3, 32'd1);
      read_reg(4'd3, rd);
      check("rnd_done_clear", rd[0], 0);
      bus_write(4'd1, p);
      bus_write(4'd2, s);
      for (int i = 0; i < 8; i++) begin
        dtab[i] = $urandom_range(0, p + 3);
        bus_write(4'd8 + 4'(i), dtab[i]);
      end
      duty_num = 3'($urandom_range(0, 7));
      bus_write(4'd0, auto_m ? 32'd7 : 32'd5);
      bus.address = 4'd3;
      len = auto_m ? (8 * (s + 1) + 2) * (p + 2) : 12 * (p + 2);
      idx = 0;
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        pos = j % (p + 2);
        n   = j / (p + 2);
        if (pos == 0) begin
          if (!auto_m && $urandom_range(0, 1) == 1) duty_num = 3'($urandom_range(0, 7));
          idx = auto_m ? (n / (s + 1)) % 8 : int'(duty_num);
        end
        exp_pwm = (pos != 0) && ((pos - 1) < dtab[idx]);
        check("rnd_pwm", pwm_out, exp_pwm);
        check("rnd_irq", irq, (j >= p + 2));
        if (auto_m && pos != 0) check("rnd_status_idx", bus.readdata[6:4], idx);
        if (!auto_m && pos != 0 && $urandom_range(0, 3) == 0) duty_num = 3'($urandom_range(0, 7));
      end
    end

    bus_write(4'd0, 32'd0);
    @(negedge clk);
    check("final_disable_pwm", pwm_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
